// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle sequencer: FSM state encodings,
// opcode/funct/ALU codes, the registered strobe bundle and its Moore decode.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  // Opcodes (instr[15:12]); 6..F are illegal.
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;

  // R-type funct (instr[5:3]); 5..7 are illegal.
  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_SLT = 3'd4;

  // ALU operation codes driven to the datapath.
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Registered per-state strobes. fetch/branch/jump are state flags that the
  // top combines with mem_rdy/zero to form irwrite, pcen and pcsrc.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       fetch;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [2:0] alucontrol;
  } ctrl_out_t;

  // Moore decode of a state into its strobe bundle; alu_code is the
  // funct-derived operation used by EXEC and ALUWB.
  function automatic ctrl_out_t moore_outs(input state_t s, input logic [2:0] alu_code);
    ctrl_out_t o;
    o = '0;
    o.alucontrol = ALU_ADD;
    case (s)
      S_FETCH:  begin o.mem_req = 1'b1; o.fetch = 1'b1; end
      S_EXEC:   o.alucontrol = alu_code;
      S_ALUWB:  begin o.regdst = 1'b1; o.regwrite = 1'b1; o.alucontrol = alu_code; end
      S_ADDIEX: o.alusrc = 1'b1;
      S_ADDIWB: begin o.alusrc = 1'b1; o.regwrite = 1'b1; end
      S_MEMADR: o.alusrc = 1'b1;
      S_MEMRD:  begin o.mem_req = 1'b1; o.iord = 1'b1; o.alusrc = 1'b1; end
      S_MEMWB:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      S_MEMWR:  begin o.mem_req = 1'b1; o.mem_we = 1'b1; o.iord = 1'b1; o.alusrc = 1'b1; end
      S_BRANCH: begin o.branch = 1'b1; o.alucontrol = ALU_SUB; end
      S_JUMP:   o.jump = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the sequencer (master) and the datapath/memory (slave).
interface multicycle_ctrl_if;
  logic [15:0] instr;
  logic        zero;
  logic        mem_rdy;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        irwrite;
  logic        pcen;
  logic        pcsrc;
  logic        jump;
  logic        alusrc;
  logic        regdst;
  logic        memtoreg;
  logic        regwrite;
  logic [2:0]  alucontrol;

  modport master (
    input  instr, zero, mem_rdy,
    output mem_req, mem_we, iord, irwrite, pcen, pcsrc, jump,
           alusrc, regdst, memtoreg, regwrite, alucontrol
  );

  modport slave (
    output instr, zero, mem_rdy,
    input  mem_req, mem_we, iord, irwrite, pcen, pcsrc, jump,
           alusrc, regdst, memtoreg, regwrite, alucontrol
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unused codes.
module multicycle_ctrl_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [2:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  // Funct lookup; unused codes fall back to add and raise illegal.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (funct)
      F_ADD:   alucontrol = ALU_ADD;
      F_SUB:   alucontrol = ALU_SUB;
      F_AND:   alucontrol = ALU_AND;
      F_OR:    alucontrol = ALU_OR;
      F_SLT:   alucontrol = ALU_SLT;
      default: illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: Moore FSM stepping fetch/decode/execute/memory/
// writeback and driving the datapath strobes over multicycle_ctrl_if.
// Optional memory-wait timeout is enabled by defining CTRL_TIMEOUT_EN,
// which also adds the TIMEOUT_CYCLES parameter (1..255).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
`ifdef CTRL_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus,
  output logic [3:0]        state,
  output logic              trap,
  output logic              timeout,
  output logic [15:0]       retired
);

  state_t      state_q;
  state_t      state_d;
  ctrl_out_t   outs_q;
  logic        trap_q;
  logic [15:0] retired_q;
  logic [2:0]  dec_alu;
  logic        dec_illegal;
  logic        wait_expired;
  logic [3:0]  opcode;
  logic        unused_instr;

  assign opcode       = bus.instr[15:12];
  assign unused_instr = ^{bus.instr[11:6], bus.instr[2:0]};

  multicycle_ctrl_alu_dec u_alu_dec (
    .funct      (bus.instr[5:3]),
    .alucontrol (dec_alu),
    .illegal    (dec_illegal)
  );

`ifdef CTRL_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_q;
  logic       timeout_q;

  // Counts stalled memory cycles; restarts on completion or any state change.
  always_ff @(posedge clk) begin
    if (!reset)
      wait_q <= '0;
    else if (bus.mem_rdy || !outs_q.mem_req || state_d != state_q)
      wait_q <= '0;
    else
      wait_q <= wait_q + 8'd1;
  end

  assign wait_expired = outs_q.mem_req && !bus.mem_rdy && (wait_q == WAIT_LIMIT);
  assign timeout      = timeout_q;
`else
  assign wait_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_rdy)       state_d = S_DECODE;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = dec_illegal ? S_TRAP : S_EXEC;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_TRAP;
        endcase
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_rdy)       state_d = S_MEMWB;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_rdy)       state_d = S_FETCH;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // FSM state, registered strobes, retire counter and sticky trap flags.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (!reset) begin
      state_q   <= S_FETCH;
      outs_q    <= moore_outs(S_FETCH, ALU_ADD);
      trap_q    <= 1'b0;
      retired_q <= '0;
`ifdef CTRL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      outs_q  <= moore_outs(state_d, dec_alu);
      if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
        retired_q <= retired_q + 16'd1;
      if (state_d == S_TRAP)
        trap_q <= 1'b1;
`ifdef CTRL_TIMEOUT_EN
      if (wait_expired)
        timeout_q <= 1'b1;
`endif
    end
  end

  // Strobes are forced low while reset is held so an in-flight access drops at once.
  assign bus.mem_req    = reset & outs_q.mem_req;
  assign bus.mem_we     = reset & outs_q.mem_we;
  assign bus.iord       = reset & outs_q.iord;
  assign bus.irwrite    = reset & outs_q.fetch & bus.mem_rdy;
  assign bus.pcen       = reset & ((outs_q.fetch & bus.mem_rdy) |
                                   (outs_q.branch & bus.zero) |
                                   outs_q.jump);
  assign bus.pcsrc      = reset & outs_q.branch;
  assign bus.jump       = reset & outs_q.jump;
  assign bus.alusrc     = reset & outs_q.alusrc;
  assign bus.regdst     = reset & outs_q.regdst;
  assign bus.memtoreg   = reset & outs_q.memtoreg;
  assign bus.regwrite   = reset & outs_q.regwrite;
  assign bus.alucontrol = outs_q.alucontrol;

  assign state   = state_q;
  assign trap    = trap_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, illegal
// decode, reset behaviour and the memory-wait timeout (CTRL_TIMEOUT_EN).
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic        trap;
  logic        timeout;
  logic [15:0] retired;
  logic [10:0] strb;
  int          total = 0;
  int          bad   = 0;

  // Strobe vector bit positions: {mem_req, mem_we, iord, irwrite, pcen,
  // pcsrc, jump, alusrc, regdst, memtoreg, regwrite}.
  localparam logic [10:0] NONE   = 11'b000_0000_0000;
  localparam logic [10:0] MREQ   = 11'b100_0000_0000;
  localparam logic [10:0] MWE    = 11'b010_0000_0000;
  localparam logic [10:0] IORD   = 11'b001_0000_0000;
  localparam logic [10:0] IRW    = 11'b000_1000_0000;
  localparam logic [10:0] PCEN   = 11'b000_0100_0000;
  localparam logic [10:0] PCSRC  = 11'b000_0010_0000;
  localparam logic [10:0] JMP    = 11'b000_0001_0000;
  localparam logic [10:0] ALUSRC = 11'b000_0000_1000;
  localparam logic [10:0] REGDST = 11'b000_0000_0100;
  localparam logic [10:0] MTR    = 11'b000_0000_0010;
  localparam logic [10:0] RW     = 11'b000_0000_0001;

  multicycle_ctrl_if bus ();

`ifdef CTRL_TIMEOUT_EN
  multicycle_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state   (state),
    .trap    (trap),
    .timeout (timeout),
    .retired (retired)
  );
`else
  multicycle_ctrl u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state   (state),
    .trap    (trap),
    .timeout (timeout),
    .retired (retired)
  );
`endif

  always #5 clk = ~clk;

  assign strb = {bus.mem_req, bus.mem_we, bus.iord, bus.irwrite, bus.pcen,
                 bus.pcsrc, bus.jump, bus.alusrc, bus.regdst, bus.memtoreg,
                 bus.regwrite};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input state_t st, input logic [10:0] s,
                            input logic [2:0] alu);
    check({tag, " state"}, 32'(state), 32'(st));
    check({tag, " strobes"}, 32'(strb), 32'(s));
    check({tag, " alu"}, 32'(bus.alucontrol), 32'(alu));
  endtask

  initial begin
    reset       = 1'b0;
    bus.instr   = 16'h0008;
    bus.zero    = 1'b0;
    bus.mem_rdy = 1'b1;

    // Reset held 3 cycles with mem_rdy high: everything quiet.
    repeat (3) tick();
    expect_cyc("rst", S_FETCH, NONE, 3'b010);
    check("rst retired", 32'(retired), 32'd0);
    check("rst trap", 32'(trap), 32'd0);
    check("rst timeout", 32'(timeout), 32'd0);

    // SUB with two fetch wait cycles.
    bus.mem_rdy = 1'b0;
    reset       = 1'b1;
    #1;
    expect_cyc("sub fetch0", S_FETCH, MREQ, 3'b010);
    tick();
    expect_cyc("sub fetch1", S_FETCH, MREQ, 3'b010);
    tick();
    bus.mem_rdy = 1'b1;
    #1;
    expect_cyc("sub fetch2", S_FETCH, MREQ | IRW | PCEN, 3'b010);
    tick();
    expect_cyc("sub decode", S_DECODE, NONE, 3'b010);
    tick();
    expect_cyc("sub exec", S_EXEC, NONE, 3'b110);
    tick();
    expect_cyc("sub aluwb", S_ALUWB, REGDST | RW, 3'b110);
    tick();
    expect_cyc("sub done", S_FETCH, MREQ | IRW | PCEN, 3'b010);
    check("sub retired", 32'(retired), 32'd1);

    // LW with one wait cycle in MEMRD.
    bus.instr = 16'h2000;
    tick();
    expect_cyc("lw decode", S_DECODE, NONE, 3'b010);
    tick();
    expect_cyc("lw memadr", S_MEMADR, ALUSRC, 3'b010);
    bus.mem_rdy = 1'b0;
    tick();
    expect_cyc("lw memrd0", S_MEMRD, MREQ | IORD | ALUSRC, 3'b010);
    tick();
    expect_cyc("lw memrd1", S_MEMRD, MREQ | IORD | ALUSRC, 3'b010);
    bus.mem_rdy = 1'b1;
    tick();
    expect_cyc("lw memwb", S_MEMWB, MTR | RW, 3'b010);
    tick();
    expect_cyc("lw done", S_FETCH, MREQ | IRW | PCEN, 3'b010);
    check("lw retired", 32'(retired), 32'd2);

    // SW, zero wait.
    bus.instr = 16'h3000;
    tick();
    expect_cyc("sw decode", S_DECODE, NONE, 3'b010);
    tick();
    expect_cyc("sw memadr", S_MEMADR, ALUSRC, 3'b010);
    tick();
    expect_cyc("sw memwr", S_MEMWR, MREQ | MWE | IORD | ALUSRC, 3'b010);
    tick();
    check("sw state", 32'(state), 32'(S_FETCH));
    check("sw retired", 32'(retired), 32'd3);

    // BEQ taken.
    bus.instr = 16'h4000;
    bus.zero  = 1'b1;
    tick();
    expect_cyc("beq1 decode", S_DECODE, NONE, 3'b010);
    tick();
    expect_cyc("beq1 branch", S_BRANCH, PCSRC | PCEN, 3'b110);
    tick();
    check("beq1 state", 32'(state), 32'(S_FETCH));
    check("beq1 retired", 32'(retired), 32'd4);

    // BEQ not taken.
    bus.zero = 1'b0;
    tick();
    tick();
    expect_cyc("beq0 branch", S_BRANCH, PCSRC, 3'b110);
    tick();
    check("beq0 state", 32'(state), 32'(S_FETCH));
    check("beq0 retired", 32'(retired), 32'd5);

    // J.
    bus.instr = 16'h5000;
    tick();
    tick();
    expect_cyc("j jump", S_JUMP, JMP | PCEN, 3'b010);
    tick();
    check("j retired", 32'(retired), 32'd6);

    // ADDI.
    bus.instr = 16'h1000;
    tick();
    expect_cyc("addi decode", S_DECODE, NONE, 3'b010);
    tick();
    expect_cyc("addi ex", S_ADDIEX, ALUSRC, 3'b010);
    tick();
    expect_cyc("addi wb", S_ADDIWB, ALUSRC | RW, 3'b010);
    tick();
    check("addi retired", 32'(retired), 32'd7);

    // SLT (funct 4).
    bus.instr = 16'h0020;
    tick();
    tick();
    expect_cyc("slt exec", S_EXEC, NONE, 3'b111);
    tick();
    expect_cyc("slt aluwb", S_ALUWB, REGDST | RW, 3'b111);
    tick();
    check("slt retired", 32'(retired), 32'd8);

    // Illegal opcode F: trap, absorbing for 20 cycles.
    bus.instr = 16'hF000;
    tick();
    tick();
    expect_cyc("opf trap", S_TRAP, NONE, 3'b010);
    check("opf trap flag", 32'(trap), 32'd1);
    check("opf timeout flag", 32'(timeout), 32'd0);
    repeat (20) tick();
    expect_cyc("opf held", S_TRAP, NONE, 3'b010);
    check("opf held trap", 32'(trap), 32'd1);
    check("opf held retired", 32'(retired), 32'd8);

    // Reset clears trap and retired.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    expect_cyc("rst2", S_FETCH, MREQ | IRW | PCEN, 3'b010);
    check("rst2 trap", 32'(trap), 32'd0);
    check("rst2 retired", 32'(retired), 32'd0);

    // Illegal R-type funct 7.
    bus.instr = 16'h0038;
    tick();
    tick();
    expect_cyc("f7 trap", S_TRAP, NONE, 3'b010);
    check("f7 trap flag", 32'(trap), 32'd1);

    // Reset mid-access drops mem_req immediately.
    reset = 1'b0;
    tick();
    reset       = 1'b1;
    bus.mem_rdy = 1'b0;
    #1;
    expect_cyc("drop pre", S_FETCH, MREQ, 3'b010);
    tick();
    reset = 1'b0;
    #1;
    check("drop strobes", 32'(strb), 32'(NONE));
    tick();
    reset = 1'b1;
    #1;

    // Memory never answers.
`ifdef CTRL_TIMEOUT_EN
    repeat (3) tick();
    expect_cyc("to wait3", S_FETCH, MREQ, 3'b010);
    check("to wait3 timeout", 32'(timeout), 32'd0);
    tick();
    expect_cyc("to trap", S_TRAP, NONE, 3'b010);
    check("to trap flag", 32'(trap), 32'd1);
    check("to timeout flag", 32'(timeout), 32'd1);
`else
    repeat (100) tick();
    expect_cyc("nto wait", S_FETCH, MREQ, 3'b010);
    check("nto trap", 32'(trap), 32'd0);
    check("nto timeout", 32'(timeout), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
